pipeline_hazard_controller: RTL and testbench

Sequencing controller for the 16-bit five-stage pipelined datapath (IF/ID/EX/MEM/WB, 4-bit opcode in instr[15:12], 8×16 register file).
- Decides each cycle whether each pipeline register advances, holds or is flushed, covering load-use hazards, taken BNE, memory wait states and an external halt/drain/resume handshake.
- Keeps saturating stall and flush counters for debug.
- Sits beside the decode control unit and drives the enables and flushes of the PC and all pipeline registers.

---
 rtl/pipe_pkg.sv | 30 +++
 rtl/load_use_detect.sv | 26 ++
 rtl/pipeline_hazard_controller.sv | 156 +++++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the five-stage pipeline sequencing logic:
// opcodes, controller states and the operand-usage helper.
package pipe_pkg;

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_OR  = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd6;
    localparam logic [3:0] OP_SLT = 4'd7;
    localparam logic [3:0] OP_LW  = 4'd8;
    localparam logic [3:0] OP_SW  = 4'd10;
    localparam logic [3:0] OP_BNE = 4'd14;

    localparam int CTRL_W = 11;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    // True for instructions whose rt field is a source operand.
    function automatic logic uses_rt(input logic [3:0] op);
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_SW, OP_BNE: uses_rt = 1'b1;
            default:                                               uses_rt = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Flags an instruction in ID that consumes the destination of a load
// still in EX, which cannot be satisfied by forwarding.
module load_use_detect
    import pipe_pkg::*;
(
    input  logic [15:0] ifid_instr,
    input  logic        idex_memread,
    input  logic [2:0]  idex_rt,
    output logic        lu
);

    logic [3:0] op;
    logic [2:0] rs;
    logic [2:0] rt;
    logic       unused_bits;

    assign op          = ifid_instr[15:12];
    assign rs          = ifid_instr[11:9];
    assign rt          = ifid_instr[8:6];
    assign unused_bits = ^ifid_instr[5:0];

    // r0 is hardwired to zero, so a load into it never creates a dependency.
    assign lu = idex_memread && (idex_rt != 3'd0) &&
                ((idex_rt == rs) || (uses_rt(op) && (idex_rt == rt)));

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Per-cycle advance/hold/flush decisions for the PC and pipeline registers,
// plus the halt/drain/resume FSM and saturating debug counters.
module pipeline_hazard_controller
    import pipe_pkg::*;
#(
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      ifid_instr,
    input  logic             idex_memread,
    input  logic [2:0]       idex_rt,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             halt_req,
    input  logic             resume_req,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             pipe_freeze,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r;
    state_t           state_next;
    logic [3:0]       drain_r;
    logic [3:0]       drain_next;
    logic             halted_r;
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;
    logic             lu;
    logic             mw;
    logic             stall_evt;
    logic             flush_evt;

    load_use_detect u_lu (
        .ifid_instr   (ifid_instr),
        .idex_memread (idex_memread),
        .idex_rt      (idex_rt),
        .lu           (lu)
    );

    assign mw        = mem_req && !mem_ready;
    assign stall_evt = mw || (!ex_branch_taken && lu);
    assign flush_evt = !mw && ex_branch_taken;

    // State, drain counter and halted flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_RUN;
            drain_r  <= 4'd0;
            halted_r <= 1'b0;
        end else begin
            state_r  <= state_next;
            drain_r  <= drain_next;
            halted_r <= (state_next == ST_HALTED);
        end
    end

    // Next-state logic; a frozen or load-use cycle does not count toward the drain.
    always_comb begin
        state_next = state_r;
        drain_next = drain_r;
        case (state_r)
            ST_RUN: begin
                if (halt_req) begin
                    state_next = ST_DRAIN;
                    drain_next = 4'(DRAIN_CYCLES);
                end else begin
                    drain_next = drain_r;
                end
            end
            ST_DRAIN: begin
                if (!mw && !lu) begin
                    if (drain_r == 4'd1) begin
                        state_next = ST_HALTED;
                        drain_next = 4'd0;
                    end else begin
                        drain_next = drain_r - 4'd1;
                    end
                end else begin
                    drain_next = drain_r;
                end
            end
            ST_HALTED: begin
                if (resume_req) begin
                    state_next = ST_RUN;
                end else begin
                    state_next = ST_HALTED;
                end
            end
            default: begin
                state_next = ST_RUN;
                drain_next = 4'd0;
            end
        endcase
    end

    // Hazard priority mux: memory wait, taken branch, load-use, then state default.
    always_comb begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        pipe_freeze = 1'b0;
        if (rst) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (mw) begin
            pipe_freeze = 1'b1;
        end else if (ex_branch_taken) begin
            pc_write   = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (lu) begin
            idex_flush = 1'b1;
        end else begin
            case (state_r)
                ST_RUN: begin
                    pc_write   = 1'b1;
                    ifid_write = 1'b1;
                end
                ST_DRAIN:  ifid_flush = 1'b1;
                ST_HALTED: idex_flush = 1'b1;
                default:   idex_flush = 1'b1;
            endcase
        end
    end

    // Saturating debug counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_r <= '0;
            flush_cnt_r <= '0;
        end else begin
            if (stall_evt && (stall_cnt_r != '1)) begin
                stall_cnt_r <= stall_cnt_r + CNT_ONE;
            end
            if (flush_evt && (flush_cnt_r != '1)) begin
                flush_cnt_r <= flush_cnt_r + CNT_ONE;
            end
        end
    end

    assign halted    = halted_r;
    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed and randomized check of pipeline_hazard_controller against a
// behavioural model of the hazard priority rules and halt handshake.
module tb_pipeline_hazard_controller;

    localparam int DC = 4;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   ifid_instr;
    logic          idex_memread;
    logic [2:0]    idex_rt;
    logic          ex_branch_taken;
    logic          mem_req;
    logic          mem_ready;
    logic          halt_req;
    logic          resume_req;
    logic          pc_write, ifid_write, ifid_flush, idex_flush, pipe_freeze, halted;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int total = 0;
    int bad   = 0;

    // Model: mode 0=run 1=drain 2=halted
    int m_mode, m_drain, m_stall, m_flush;

    pipeline_hazard_controller #(.DRAIN_CYCLES(DC), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .ifid_instr(ifid_instr), .idex_memread(idex_memread),
        .idex_rt(idex_rt), .ex_branch_taken(ex_branch_taken), .mem_req(mem_req),
        .mem_ready(mem_ready), .halt_req(halt_req), .resume_req(resume_req),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_flush(idex_flush), .pipe_freeze(pipe_freeze), .halted(halted),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_lu();
        int op, rs, rt;
        bit reads;
        op    = int'(ifid_instr[15:12]);
        rs    = int'(ifid_instr[11:9]);
        rt    = int'(ifid_instr[8:6]);
        reads = (op == 0) || (op == 1) || (op == 2) || (op == 6) || (op == 7) ||
                (op == 10) || (op == 14);
        return idex_memread && (idex_rt != 3'd0) &&
               ((int'(idex_rt) == rs) || (reads && int'(idex_rt) == rt));
    endfunction

    task automatic set_in(input logic [15:0] instr, input logic mr, input logic [2:0] rt,
                          input logic br, input logic mq, input logic mrdy,
                          input logic hr, input logic rr);
        ifid_instr = instr; idex_memread = mr; idex_rt = rt; ex_branch_taken = br;
        mem_req = mq; mem_ready = mrdy; halt_req = hr; resume_req = rr;
    endtask

    // One clock: check combinational outputs mid-cycle, advance model, check registers.
    task automatic cycle();
        bit mw, lu, br;
        logic e_pc, e_ifw, e_iff, e_idf, e_frz;
        int sat;
        sat = (1 << CW) - 1;
        #3;
        if (rst) begin
            m_mode = 0; m_drain = 0; m_stall = 0; m_flush = 0;
        end
        mw = mem_req && !mem_ready;
        lu = model_lu();
        br = ex_branch_taken;
        {e_pc, e_ifw, e_iff, e_idf, e_frz} = 5'b00000;
        if (rst)      begin e_iff = 1'b1; e_idf = 1'b1; end
        else if (mw)  e_frz = 1'b1;
        else if (br)  begin e_pc = 1'b1; e_iff = 1'b1; e_idf = 1'b1; end
        else if (lu)  e_idf = 1'b1;
        else if (m_mode == 0) begin e_pc = 1'b1; e_ifw = 1'b1; end
        else if (m_mode == 1) e_iff = 1'b1;
        else e_idf = 1'b1;
        chk("pc_write", 32'(pc_write), 32'(e_pc));
        chk("ifid_write", 32'(ifid_write), 32'(e_ifw));
        chk("ifid_flush", 32'(ifid_flush), 32'(e_iff));
        chk("idex_flush", 32'(idex_flush), 32'(e_idf));
        chk("pipe_freeze", 32'(pipe_freeze), 32'(e_frz));
        chk("halted_pre", 32'(halted), 32'(m_mode == 2));
        chk("stall_pre", 32'(stall_cnt), 32'(m_stall));
        chk("flush_pre", 32'(flush_cnt), 32'(m_flush));
        @(posedge clk);
        #1;
        if (!rst) begin
            if ((mw || (!br && lu)) && m_stall < sat) m_stall++;
            if (!mw && br && m_flush < sat) m_flush++;
            if (m_mode == 0) begin
                if (halt_req) begin m_mode = 1; m_drain = DC; end
            end else if (m_mode == 1) begin
                if (!mw && !lu) begin
                    if (m_drain == 1) begin m_mode = 2; m_drain = 0; end
                    else m_drain--;
                end
            end else if (resume_req) begin
                m_mode = 0;
            end
        end
        chk("halted", 32'(halted), 32'(m_mode == 2));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        chk("flush_cnt", 32'(flush_cnt), 32'(m_flush));
    endtask

    initial begin
        m_mode = 0; m_drain = 0; m_stall = 0; m_flush = 0;
        rst = 1'b1;
        set_in(16'h0000, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        cycle();
        cycle();
        rst = 1'b0;

        // Load-use: ADD r3,r1,r2 behind LW r1
        set_in(16'h2298, 1'b1, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle();
        chk("lu_stall_one", 32'(stall_cnt), 32'd1);
        set_in(16'h2298, 1'b0, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle();

        // LW r4,(r1) behind LW into r0: no stall
        set_in(16'h8300, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        #2;
        chk("lw_r0_pc_write", 32'(pc_write), 32'd1);
        #1; #(-3+3);
        cycle();

        // Branch wins over load-use
        set_in(16'h2298, 1'b1, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle();

        // Memory wait holds off a pending branch for 3 cycles
        set_in(16'h0000, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle();
        mem_ready = 1'b1;
        cycle();
        ex_branch_taken = 1'b0; mem_req = 1'b0;

        // Halt pulse, drain, resume
        halt_req = 1'b1;
        cycle();
        halt_req = 1'b0;
        for (int i = 0; i < DC; i++) cycle();
        chk("halted_after_drain", 32'(halted), 32'd1);
        cycle();
        resume_req = 1'b1;
        cycle();
        resume_req = 1'b0;
        cycle();

        // Reset in the middle of a drain
        halt_req = 1'b1;
        cycle();
        halt_req = 1'b0;
        cycle(); cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();

        // Saturate stall_cnt with memory waits, then one more load-use stall
        set_in(16'h0000, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 65540; i++) cycle();
        chk("stall_sat", 32'(stall_cnt), 32'hFFFF);
        set_in(16'h2298, 1'b1, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle();
        chk("stall_sat_hold", 32'(stall_cnt), 32'hFFFF);
        rst = 1'b1;
        cycle();
        rst = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            ifid_instr      = 16'($urandom);
            idex_memread    = ($urandom_range(0, 2) == 0);
            idex_rt         = 3'($urandom_range(0, 7));
            ex_branch_taken = ($urandom_range(0, 5) == 0);
            mem_req         = ($urandom_range(0, 2) == 0);
            mem_ready       = ($urandom_range(0, 1) == 0);
            halt_req        = ($urandom_range(0, 15) == 0);
            resume_req      = ($urandom_range(0, 3) == 0);
            rst             = ($urandom_range(0, 299) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
